// File: rtl/regfile_write_arbiter.sv
// Two-requester register-file write arbiter with a round-robin priority pointer.
// Optional macro ZERO_REG_GUARD_EN suppresses the commit of writes aimed at address 0.
module regfile_write_arbiter #(
    parameter int unsigned RegFileAdd    = 5,
    parameter int unsigned RegFile_width = 32
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     Hold,
    input  logic                     ReqA_Valid,
    input  logic [RegFileAdd-1:0]    ReqA_Addr,
    input  logic [RegFile_width-1:0] ReqA_Data,
    output logic                     ReqA_Ready,
    input  logic                     ReqB_Valid,
    input  logic [RegFileAdd-1:0]    ReqB_Addr,
    input  logic [RegFile_width-1:0] ReqB_Data,
    output logic                     ReqB_Ready,
    output logic                     WE3,
    output logic [RegFileAdd-1:0]    A3,
    output logic [RegFile_width-1:0] WD3,
    output logic                     LastGrant,
    output logic [15:0]              WrCount
);

`ifdef ZERO_REG_GUARD_EN
    localparam bit ZeroGuard = 1'b1;
`else
    localparam bit ZeroGuard = 1'b0;
`endif

    logic                     ptr_q, ptr_d;
    logic                     last_q, last_d;
    logic                     we_q, we_d;
    logic [RegFileAdd-1:0]    a3_q, a3_d;
    logic [RegFile_width-1:0] wd3_q, wd3_d;
    logic [15:0]              cnt_q, cnt_d;

    logic                     hs_a, hs_b, hs_any, commit;
    logic [RegFileAdd-1:0]    sel_addr;
    logic [RegFile_width-1:0] sel_data;

    // Grant depends only on Hold, both Valids and the pointer.
    always_comb begin
        ReqA_Ready = 1'b0;
        ReqB_Ready = 1'b0;
        if (!Hold) begin
            if (ReqA_Valid && ReqB_Valid) begin
                ReqA_Ready = !ptr_q;
                ReqB_Ready = ptr_q;
            end else begin
                ReqA_Ready = ReqA_Valid;
                ReqB_Ready = ReqB_Valid;
            end
        end
    end

    assign hs_a     = ReqA_Valid && ReqA_Ready;
    assign hs_b     = ReqB_Valid && ReqB_Ready;
    assign hs_any   = hs_a || hs_b;
    assign sel_addr = hs_b ? ReqB_Addr : ReqA_Addr;
    assign sel_data = hs_b ? ReqB_Data : ReqA_Data;
    // A guarded address-0 handshake still completes but never reaches the register file.
    assign commit   = hs_any && !(ZeroGuard && (sel_addr == '0));

    always_comb begin
        ptr_d  = ptr_q;
        last_d = last_q;
        we_d   = commit;
        a3_d   = a3_q;
        wd3_d  = wd3_q;
        cnt_d  = cnt_q;
        if (hs_a) begin
            ptr_d  = 1'b1;
            last_d = 1'b0;
        end else if (hs_b) begin
            ptr_d  = 1'b0;
            last_d = 1'b1;
        end
        if (commit) begin
            a3_d  = sel_addr;
            wd3_d = sel_data;
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ptr_q  <= 1'b0;
            last_q <= 1'b0;
            we_q   <= 1'b0;
            a3_q   <= '0;
            wd3_q  <= '0;
            cnt_q  <= 16'd0;
        end else begin
            ptr_q  <= ptr_d;
            last_q <= last_d;
            we_q   <= we_d;
            a3_q   <= a3_d;
            wd3_q  <= wd3_d;
            cnt_q  <= cnt_d;
        end
    end

    assign WE3       = we_q;
    assign A3        = a3_q;
    assign WD3       = wd3_q;
    assign LastGrant = last_q;
    assign WrCount   = cnt_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized self-checking bench for regfile_write_arbiter against a behavioural model.
module tb_regfile_write_arbiter;
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

`ifdef ZERO_REG_GUARD_EN
    localparam bit Guard = 1'b1;
`else
    localparam bit Guard = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST;
    logic          Hold;
    logic          ReqA_Valid, ReqB_Valid;
    logic [AW-1:0] ReqA_Addr, ReqB_Addr;
    logic [DW-1:0] ReqA_Data, ReqB_Data;
    logic          ReqA_Ready, ReqB_Ready;
    logic          WE3;
    logic [AW-1:0] A3;
    logic [DW-1:0] WD3;
    logic          LastGrant;
    logic [15:0]   WrCount;

    int total = 0;
    int bad   = 0;

    // Reference state: which requester is preferred, and the last committed write.
    int            m_pref;   // 0 = A, 1 = B
    int            m_last;
    bit            m_we;
    logic [AW-1:0] m_a3;
    logic [DW-1:0] m_wd3;
    int            m_cnt;

    regfile_write_arbiter #(
        .RegFileAdd   (AW),
        .RegFile_width(DW)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .Hold      (Hold),
        .ReqA_Valid(ReqA_Valid),
        .ReqA_Addr (ReqA_Addr),
        .ReqA_Data (ReqA_Data),
        .ReqA_Ready(ReqA_Ready),
        .ReqB_Valid(ReqB_Valid),
        .ReqB_Addr (ReqB_Addr),
        .ReqB_Data (ReqB_Data),
        .ReqB_Ready(ReqB_Ready),
        .WE3       (WE3),
        .A3        (A3),
        .WD3       (WD3),
        .LastGrant (LastGrant),
        .WrCount   (WrCount)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pref = 0;
        m_last = 0;
        m_we   = 1'b0;
        m_a3   = '0;
        m_wd3  = '0;
        m_cnt  = 0;
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, ".we3"}, 64'(WE3), 64'(m_we));
        check_eq({tag, ".a3"}, 64'(A3), 64'(m_a3));
        check_eq({tag, ".wd3"}, 64'(WD3), 64'(m_wd3));
        check_eq({tag, ".last"}, 64'(LastGrant), 64'(m_last));
        check_eq({tag, ".cnt"}, 64'(WrCount), 64'(m_cnt % 65536));
    endtask

    // One clock cycle: drive, check grants, clock, then check registered outputs.
    task automatic step(input string tag, input logic h, input logic va, input logic vb,
                        input logic [AW-1:0] aa, input logic [AW-1:0] ab,
                        input logic [DW-1:0] da, input logic [DW-1:0] db);
        int winner;   // -1 none, 0 A, 1 B
        Hold = h; ReqA_Valid = va; ReqB_Valid = vb;
        ReqA_Addr = aa; ReqB_Addr = ab; ReqA_Data = da; ReqB_Data = db;
        #1;
        if (h)             winner = -1;
        else if (va && vb) winner = m_pref;
        else if (va)       winner = 0;
        else if (vb)       winner = 1;
        else               winner = -1;
        check_eq({tag, ".rdyA"}, 64'(ReqA_Ready), 64'(winner == 0));
        check_eq({tag, ".rdyB"}, 64'(ReqB_Ready), 64'(winner == 1));
        @(posedge CLK);
        #1;
        m_we = 1'b0;
        if (winner >= 0) begin
            logic [AW-1:0] wa;
            logic [DW-1:0] wd;
            wa     = (winner == 0) ? aa : ab;
            wd     = (winner == 0) ? da : db;
            m_pref = 1 - winner;
            m_last = winner;
            if (!(Guard && wa == 0)) begin
                m_we  = 1'b1;
                m_a3  = wa;
                m_wd3 = wd;
                m_cnt = m_cnt + 1;
            end
        end
        check_outputs(tag);
    endtask

    task automatic do_reset(input string tag);
        RST = 1'b0;
        #1;
        model_reset();
        check_outputs(tag);
        #2;
        RST = 1'b1;
    endtask

    initial begin
        RST = 1'b1; Hold = 1'b0; ReqA_Valid = 1'b0; ReqB_Valid = 1'b0;
        ReqA_Addr = '0; ReqB_Addr = '0; ReqA_Data = '0; ReqB_Data = '0;
        model_reset();
        #2;
        do_reset("rst0");
        @(posedge CLK);
        #1;

        step("single", 0, 1, 0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0);
        step("idle", 0, 0, 0, 5'd9, 5'd9, 32'h1, 32'h2);

        do_reset("rst1");
        for (int i = 0; i < 4; i++)
            step("contend", 0, 1, 1, AW'(i + 1), AW'(i + 17), DW'(i), DW'(100 + i));

        for (int i = 0; i < 3; i++)
            step("hold", 1, 1, 1, 5'd3, 5'd4, 32'hA, 32'hB);
        step("unhold", 0, 1, 1, 5'd3, 5'd4, 32'hA, 32'hB);

        do_reset("rst2");
        step("same0", 0, 1, 1, 5'd7, 5'd7, 32'd1, 32'd2);
        step("same1", 0, 1, 1, 5'd7, 5'd7, 32'd1, 32'd2);

        do_reset("rst3");
        step("zero", 0, 1, 0, 5'd0, 5'd0, 32'h55, 32'h0);

        for (int i = 0; i < 600; i++) begin
            logic          h, va, vb;
            logic [AW-1:0] aa, ab;
            h  = ($urandom_range(0, 4) == 0);
            va = ($urandom_range(0, 2) != 0);
            vb = ($urandom_range(0, 2) != 0);
            aa = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom);
            ab = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom);
            step("rand", h, va, vb, aa, ab, $urandom, $urandom);
            if (i == 250 || i == 251 || i == 480) do_reset("rstmid");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter RegFileAdd, default 5, register address width.
REQ-002 SHALL have parameter RegFile_width, default 32, data width.
REQ-003 SHALL have port CLK  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port Hold  input  1  when 1, no grant is issued this cycle.
REQ-006 SHALL have ports ReqA_Valid / ReqB_Valid  input  1  requester has a pending write.
REQ-007 SHALL have ports ReqA_Addr / ReqB_Addr  input  RegFileAdd  destination register.
REQ-008 SHALL have ports ReqA_Data / ReqB_Data  input  RegFile_width  write data.
REQ-009 SHALL have ports ReqA_Ready / ReqB_Ready  output  1  combinational grant; handshake = Valid && Ready.
REQ-010 SHALL have port WE3  output  1  register-file write enable, registered.
REQ-011 SHALL have port A3  output  RegFileAdd  register-file write address, registered.
REQ-012 SHALL have port WD3  output  RegFile_width  register-file write data, registered.
REQ-013 SHALL have port LastGrant  output  1  0 = A, 1 = B; requester of the most recent handshake.
REQ-014 SHALL have port WrCount  output  16  count of WE3 pulses, wraps 0xFFFF -> 0x0000.

Function
REQ-015 SHALL hold a 1-bit priority pointer Ptr (0 = A preferred, 1 = B preferred).
REQ-016 Grant rule: Hold=1 -> both Ready=0; only one Valid -> that requester Ready=1; both Valid -> requester selected by Ptr Ready=1, other 0; neither Valid -> both 0.
REQ-017 At most one Ready SHALL be 1 in any cycle.
REQ-018 Ready SHALL depend only on Hold, both Valid, and Ptr.
REQ-019 Ptr update: handshake on A -> Ptr=1; handshake on B -> Ptr=0; no handshake -> Ptr unchanged.
REQ-020 Latency: handshake in cycle N -> WE3=1 with A3/WD3 = granted Addr/Data in cycle N+1 only.
REQ-021 No handshake in cycle N -> WE3=0 in cycle N+1; A3/WD3 retain previous values.
REQ-022 Back-to-back handshakes SHALL produce WE3 high on consecutive cycles, one write per handshake, no drops or duplicates.
REQ-023 LastGrant SHALL update on the cycle after each handshake and otherwise hold.
REQ-024 WrCount SHALL increment by 1 on each cycle where WE3=1, modulo 2^16.
REQ-025 Both requesters targeting the same address: writes committed one per cycle in grant order; the later write wins.
REQ-026 Hold asserted while a write is registered SHALL NOT cancel it; WE3 for the prior handshake still pulses.
REQ-027 Valid deasserted without handshake SHALL leave no side effect.

Reset
REQ-028 RST low SHALL immediately force WE3=0, A3=0, WD3=0, Ptr=0, LastGrant=0, WrCount=0, independent of CLK.
REQ-029 Reset mid-operation SHALL discard any registered, uncommitted write; no WE3 pulse follows release.
REQ-030 First rising CLK edge with RST high SHALL resume normal arbitration with A preferred.

Configuration
REQ-031 Macro ZERO_REG_GUARD_EN defined: handshake to address 0 SHALL complete normally, update Ptr and LastGrant, but WE3 SHALL stay 0 and WrCount SHALL not increment.
REQ-032 ZERO_REG_GUARD_EN undefined: address 0 SHALL be treated as any other address.

Verification
REQ-033 Reset: RST=0 mid-burst -> WE3=0, A3=0, WD3=0, WrCount=0 before next CLK edge.
REQ-034 Single requester: A Valid, Addr=5, Data=0xDEADBEEF, one cycle -> next cycle WE3=1, A3=5, WD3=0xDEADBEEF, WrCount=1.
REQ-035 Contention: A and B Valid for 4 cycles after reset -> grant order A,B,A,B; WE3 high 4 consecutive cycles; WrCount=4.
REQ-036 Hold: both Valid, Hold=1 for 3 cycles -> both Ready=0, WE3=0 from second cycle, Ptr unchanged; Hold=0 -> preferred requester granted.
REQ-037 Same address: A Addr=7 Data=1, B Addr=7 Data=2, both Valid, Ptr=0 -> A3=7 WD3=1, then A3=7 WD3=2.
REQ-038 Zero guard: A Addr=0 Data=0x55 handshake -> with ZERO_REG_GUARD_EN WE3=0, WrCount unchanged, LastGrant=0; without it WE3=1, A3=0, WD3=0x55.
